// File: rtl/fcvt_s2d_seq.sv
// fcvt_s2d_seq: single-to-double FP converter with serial subnormal normalisation and valid/ready handshakes
module fcvt_s2d_seq #(
  parameter int BUS_WIDTH     = 64,
  parameter bit NAN_BOX_CHECK = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 nv_flag
);
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t state, state_nxt;
  logic [23:0] m;
  logic [10:0] x;
  logic sgn;
  logic s_in;
  logic [7:0] e_in;
  logic [22:0] m_in;
  logic boxed, accept, sub, res_nv;
  logic [63:0] res;
  assign s_in = in1[31];
  assign e_in = in1[30:23];
  assign m_in = in1[22:0];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign boxed = !NAN_BOX_CHECK || in1[63:32] == 32'hFFFFFFFF;
  assign sub = boxed && e_in == 8'd0 && m_in != 23'd0;
  always_comb begin
    res = !boxed ? QNAN
        : e_in == 8'hFF ? (m_in != 23'd0 ? QNAN : {s_in, 11'h7FF, 52'd0})
        : e_in == 8'd0 ? {s_in, 63'd0}
        : {s_in, {3'd0, e_in} + 11'd896, m_in, 29'd0};
    res_nv = boxed && e_in == 8'hFF && m_in != 23'd0 && !m_in[22];
    state_nxt = state == IDLE ? (accept ? (sub ? NORM : DONE) : IDLE)
              : state == NORM ? (m[22] ? DONE : NORM)
              : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      out     <= '0;
      nv_flag <= 1'b0;
      m       <= '0;
      x       <= '0;
      sgn     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sgn     <= s_in;
        m       <= {1'b0, m_in};
        x       <= 11'd897;
        out     <= res;
        nv_flag <= res_nv;
      end else if (state == NORM) begin
        m <= m << 1;
        x <= x - 11'd1;
        if (m[22]) out <= {sgn, x - 11'd1, m[21:0], 30'd0};
      end
    end
  end
endmodule

// File: tb/tb_fcvt_s2d_seq.sv
// tb_fcvt_s2d_seq: randomized and directed checks of fcvt_s2d_seq against an arithmetic conversion model
module tb_fcvt_s2d_seq;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [63:0] in1 = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [63:0] out;
  logic nv_flag;
  int vectors = 0;
  int miscompares = 0;
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  int m_cnt = 0;
  logic [63:0] m_exp = '0;
  logic m_nv = 1'b0;
  logic [63:0] eo;
  logic en;
  int es;

  fcvt_s2d_seq #(.BUS_WIDTH(64), .NAN_BOX_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in1(in1),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .nv_flag(nv_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic void ref_model(input logic [63:0] v, output logic [63:0] o, output logic nv, output int s);
    logic sg;
    logic [7:0] e;
    logic [22:0] f;
    int p;
    sg = v[31]; e = v[30:23]; f = v[22:0]; nv = 1'b0; s = 0; p = 0;
    if (v[63:32] != 32'hFFFFFFFF) o = QNAN;
    else if (e == 8'hFF) begin
      o = (f != 0) ? QNAN : {sg, 11'h7FF, 52'd0};
      nv = (f != 0) && !f[22];
    end else if (e == 8'd0 && f == 23'd0) o = {sg, 63'd0};
    else if (e == 8'd0) begin
      for (int i = 0; i < 23; i++) if (f[i]) p = i;
      s = 23 - p;
      o = {sg, 11'(874 + p), 52'({29'd0, f} << (52 - p))};
    end else o = {sg, 11'(e) + 11'd896, f, 29'd0};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end else if (in_valid) begin
      ref_model(in1, eo, en, es);
      m_exp <= eo;
      m_nv  <= en;
      if (es == 0) m_done <= 1'b1;
      else begin
        m_busy <= 1'b1;
        m_cnt  <= es;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 64'(out_valid), 64'(m_done));
      chk("in_ready", 64'(in_ready), 64'(!(m_busy || m_done)));
      if (m_done) begin
        chk("out", out, m_exp);
        chk("nv_flag", 64'(nv_flag), 64'(m_nv));
      end
    end
  end

  task automatic run_op(input logic [63:0] v, input bit bp);
    int guard;
    int dcnt;
    guard = 0;
    dcnt = 0;
    @(negedge clk);
    in1 = v;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    do begin
      if (m_done) dcnt++;
      in_valid = bp ? 1'b1 : 1'($urandom_range(0, 1));
      in1 = {$urandom, $urandom};
      out_ready = m_done && (bp ? dcnt > 5 : $urandom_range(0, 2) != 0);
      @(negedge clk);
      guard++;
    end while ((m_busy || m_done) && guard < 100);
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (guard >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL op_timeout: in1 %h still pending after %0d cycles", v, guard);
    end
  endtask

  logic [63:0] pin_in  [9] = '{64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_C0200000, 64'hFFFFFFFF_7F800001,
                               64'hFFFFFFFF_7FC00000, 64'hFFFFFFFF_00000001, 64'hFFFFFFFF_00400000,
                               64'h00000000_3F800000, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_FF800000};
  logic [63:0] pin_out [9] = '{64'h3FF0000000000000, 64'hC004000000000000, 64'h7FF8000000000000,
                               64'h7FF8000000000000, 64'h36A0000000000000, 64'h3800000000000000,
                               64'h7FF8000000000000, 64'h8000000000000000, 64'hFFF0000000000000};
  logic        pin_nv  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int          pin_s   [9] = '{0, 0, 0, 0, 23, 1, 0, 0, 0};

  initial begin
    logic [63:0] po;
    logic pn;
    int ps;
    logic [63:0] v;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out", out, 64'd0);
    chk("reset_nv", 64'(nv_flag), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ref_model(pin_in[i], po, pn, ps);
      chk("pin_out", po, pin_out[i]);
      chk("pin_nv", 64'(pn), 64'(pin_nv[i]));
      chk("pin_shift", 64'(ps), 64'(pin_s[i]));
    end
    for (int i = 0; i < 9; i++) run_op(pin_in[i], 1'b0);
    run_op(64'hFFFFFFFF_3F800000, 1'b1);
    run_op(64'hFFFFFFFF_00000123, 1'b1);
    @(negedge clk);
    in1 = 64'hFFFFFFFF_00000001;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midnorm_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midnorm_rst_in_ready", 64'(in_ready), 64'd1);
    chk("midnorm_rst_out", out, 64'd0);
    repeat (30) @(negedge clk);
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 6))
        0: v = {32'hFFFFFFFF, 1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        1: v = {32'hFFFFFFFF, 1'($urandom), 8'd0, 23'($urandom_range(1, 32'h7FFFFF) >> $urandom_range(0, 22))};
        2: v = {32'hFFFFFFFF, 1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
        3: v = {32'hFFFFFFFF, 1'($urandom), 8'hFF, 23'd0};
        4: v = {32'hFFFFFFFF, 1'($urandom), 31'd0};
        5: v = {$urandom_range(0, 32'hFFFFFFFE), $urandom};
        default: v = {32'hFFFFFFFF, $urandom};
      endcase
      if (v[31:0] == 32'h00000000 && v[63:32] == 32'hFFFFFFFF && n % 2 == 1) v[0] = 1'b1;
      run_op(v, n % 16 == 0);
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
